// File: rtl/axis_frame_packer_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkt_pkg
//   Shared definitions for the C2H frame packer: packet-geometry helper
//   functions, default-configuration geometry and the FSM state encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package axis_pkt_pkg;

    localparam int DEF_DATA_WIDTH      = 16000;
    localparam int DEF_AXIS_DATA_WIDTH = 512;
    localparam int DEF_SEQ_WIDTH       = 8;
    localparam int DEF_DEPTH           = 4;

    // Number of stream beats needed to carry tot bits on a w-bit bus.
    function automatic int f_beats(input int tot, input int w);
        return (tot + w - 1) / w;
    endfunction

    // Number of valid bytes on the final beat.
    function automatic int f_last_keep(input int tot, input int w);
        return (tot - (f_beats(tot, w) - 1) * w + 7) / 8;
    endfunction

    // Geometry of the default build; instances recompute their own.
    localparam int BEATS  = f_beats(DEF_SEQ_WIDTH + DEF_DATA_WIDTH, DEF_AXIS_DATA_WIDTH);
    localparam int LASTB  = f_last_keep(DEF_SEQ_WIDTH + DEF_DATA_WIDTH, DEF_AXIS_DATA_WIDTH);
    localparam int KEEP_W = DEF_AXIS_DATA_WIDTH / 8;

    // One-hot for ILA visibility; bit 2 is reserved and stays 0.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        SEND = 3'b010
    } state_t;

endpackage

// File: rtl/axis_frame_packer_if.sv
// ---------------------------------------------------------------------------
// axis_frame_packer_if
//   AXI-Stream C2H bus between the frame packer and the XDMA core.
//   Signals: tdata, tkeep, tlast, tvalid (source -> sink), tready (sink -> source)
//   Modports: master (packer side), slave (DMA / testbench side)
// ---------------------------------------------------------------------------
interface axis_frame_packer_if #(
    parameter int AXIS_DATA_WIDTH = 512
) ();
    logic [AXIS_DATA_WIDTH-1:0]   tdata;
    logic [AXIS_DATA_WIDTH/8-1:0] tkeep;
    logic                         tlast;
    logic                         tvalid;
    logic                         tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_frame_packer_fifo.sv
// ---------------------------------------------------------------------------
// axis_frame_fifo
//   First-word-fall-through frame FIFO, DEPTH x WIDTH. Storage is a plain
//   array with a registered read into an output register, so the head word
//   (rd_data) is valid whenever empty is low.
//   Ports: m_axis_c2h_aclk, rst (sync, active high), push + wr_data,
//          pop, rd_data, full, empty, level (words held incl. head register)
// ---------------------------------------------------------------------------
module axis_frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       m_axis_c2h_aclk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    mem_cnt_reg;     // words in the array, not yet in the head register
    logic [WIDTH-1:0] dout_reg;
    logic             dout_valid_reg;
    logic             refill;

    // Move the oldest array word into the head register when it is free or
    // being consumed this cycle. The total held is capped at DEPTH, so the
    // write address never collides with the read address of a live word.
    assign refill = (mem_cnt_reg != '0) && (!dout_valid_reg || pop);

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (refill) begin
            dout_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            mem_cnt_reg    <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (refill) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            mem_cnt_reg <= mem_cnt_reg + LW'(push) - LW'(refill);
            if (refill) begin
                dout_valid_reg <= 1'b1;
            end else if (pop) begin
                dout_valid_reg <= 1'b0;
            end
        end
    end

    assign rd_data = dout_reg;
    assign level   = mem_cnt_reg + LW'(dout_valid_reg);
    assign full    = (level == LW'(DEPTH));
    assign empty   = !dout_valid_reg;

endmodule

// File: rtl/axis_frame_packer.sv
// ---------------------------------------------------------------------------
// axis_frame_packer
//   Packs DATA_WIDTH-bit core frames, tagged with a SEQ_WIDTH sequence number,
//   into multi-beat AXI-Stream packets for the XDMA C2H channel. Packet bit
//   stream is {zero pad, data, seq}, sent LSB first; the final beat carries
//   tlast and a byte-masked tkeep. Packets go back-to-back with no idle beat.
//   Ports: m_axis_c2h_aclk, rst (sync, active high)
//          data / data_valid / data_next : frame input handshake
//          m_axis_c2h (axis_frame_packer_if.master) : stream output
//          fifo_level : frames queued (not counting the one being sent)
//          frame_cnt  : packets fully sent; drop_cnt : frames dropped
//          sstate     : one-hot FSM state
//   Build option: define AXIS_FRAME_DROP_EN to keep data_next high and drop
//   (and count) frames offered while the FIFO is full. Without it, data_next
//   back-pressures and drop_cnt stays 0.
// ---------------------------------------------------------------------------
module axis_frame_packer
    import axis_pkt_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
    parameter int SEQ_WIDTH       = DEF_SEQ_WIDTH,
    parameter int DEPTH           = DEF_DEPTH
) (
    input  logic                       m_axis_c2h_aclk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      data,
    input  logic                       data_valid,
    output logic                       data_next,
    axis_frame_packer_if.master        m_axis_c2h,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic [31:0]                frame_cnt,
    output logic [31:0]                drop_cnt,
    output logic [2:0]                 sstate
);
    localparam int FW         = SEQ_WIDTH + DATA_WIDTH;
    localparam int PKT_BEATS  = f_beats(FW, AXIS_DATA_WIDTH);
    localparam int PKT_LASTB  = f_last_keep(FW, AXIS_DATA_WIDTH);
    localparam int PKT_KEEP_W = AXIS_DATA_WIDTH / 8;
    localparam int SH_W       = PKT_BEATS * AXIS_DATA_WIDTH;
    localparam int BC_W       = $clog2(PKT_BEATS + 1);
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(PKT_BEATS - 1);

    // Final-beat byte mask: low PKT_LASTB bytes enabled.
    logic [PKT_KEEP_W-1:0] last_keep;
    for (genvar gi = 0; gi < PKT_KEEP_W; gi++) begin : g_last_keep
        assign last_keep[gi] = (gi < PKT_LASTB) ? 1'b1 : 1'b0;
    end

    // ---------------- input side ----------------
    logic                 full;
    logic                 empty;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [FW-1:0]        head;
    logic [SEQ_WIDTH-1:0] seq_reg;

`ifdef AXIS_FRAME_DROP_EN
    logic [31:0] drop_cnt_reg;

    assign data_next = ~rst;

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (data_valid && full) begin
            drop_cnt_reg <= drop_cnt_reg + 32'd1;
        end
    end
    assign drop_cnt = drop_cnt_reg;
`else
    assign data_next = ~full;
    assign drop_cnt  = '0;
`endif

    // The sequence number advances on every accepted offer, including dropped
    // ones, so the host can see gaps.
    assign accept = data_valid & data_next;
    assign push   = accept & ~full;

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (rst) begin
            seq_reg <= '0;
        end else if (accept) begin
            seq_reg <= seq_reg + 1'b1;
        end
    end

    axis_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .m_axis_c2h_aclk (m_axis_c2h_aclk),
        .rst             (rst),
        .push            (push),
        .wr_data         ({data, seq_reg}),
        .pop             (pop),
        .rd_data         (head),
        .full            (full),
        .empty           (empty),
        .level           (fifo_level)
    );

    // ---------------- output FSM ----------------
    state_t                  state_reg,  state_next;
    logic [SH_W-1:0]         shift_reg,  shift_next;
    logic [BC_W-1:0]         beat_reg,   beat_next;
    logic                    tvalid_reg, tvalid_next;
    logic                    tlast_reg,  tlast_next;
    logic [PKT_KEEP_W-1:0]   tkeep_reg,  tkeep_next;
    logic [31:0]             frame_cnt_reg;
    logic                    frame_done;
    logic [BC_W-1:0]         beat_inc;

    assign beat_inc = beat_reg + 1'b1;

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            beat_reg      <= '0;
            tvalid_reg    <= 1'b0;
            tlast_reg     <= 1'b0;
            tkeep_reg     <= '0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            beat_reg   <= beat_next;
            tvalid_reg <= tvalid_next;
            tlast_reg  <= tlast_next;
            tkeep_reg  <= tkeep_next;
            if (frame_done) begin
                frame_cnt_reg <= frame_cnt_reg + 32'd1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        beat_next   = beat_reg;
        tvalid_next = tvalid_reg;
        tlast_next  = tlast_reg;
        tkeep_next  = tkeep_reg;
        pop         = 1'b0;
        frame_done  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                end
            end
            SEND: begin
                if (m_axis_c2h.tready) begin
                    if (beat_reg == LAST_BEAT) begin
                        frame_done = 1'b1;
                        if (!empty) begin
                            pop = 1'b1;   // next packet follows with no bubble
                        end else begin
                            state_next  = IDLE;
                            tvalid_next = 1'b0;
                            tlast_next  = 1'b0;
                            tkeep_next  = '0;
                        end
                    end else begin
                        shift_next = shift_reg >> AXIS_DATA_WIDTH;
                        beat_next  = beat_inc;
                        tlast_next = (beat_inc == LAST_BEAT);
                        tkeep_next = (beat_inc == LAST_BEAT) ? last_keep : '1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Loading a frame presents its beat 0 on the following cycle.
        if (pop) begin
            state_next  = SEND;
            shift_next  = SH_W'(head);
            beat_next   = '0;
            tvalid_next = 1'b1;
            tlast_next  = (PKT_BEATS == 1);
            tkeep_next  = (PKT_BEATS == 1) ? last_keep : '1;
        end
    end

    assign m_axis_c2h.tdata  = shift_reg[AXIS_DATA_WIDTH-1:0];
    assign m_axis_c2h.tkeep  = tkeep_reg;
    assign m_axis_c2h.tlast  = tlast_reg;
    assign m_axis_c2h.tvalid = tvalid_reg;
    assign frame_cnt         = frame_cnt_reg;
    assign sstate            = state_reg;

endmodule

// File: tb/tb_axis_frame_packer.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_packer
//   Directed bench for axis_frame_packer: a DATA_WIDTH=1000 instance (two-beat
//   packets) and a DATA_WIDTH=504 instance (single-beat packets).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_frame_packer;
    localparam int DW  = 1000;
    localparam int DW1 = 504;
    localparam int W   = 512;
    localparam int SW  = 8;
    localparam int DEP = 4;
    localparam int KW  = W / 8;
    localparam logic [KW-1:0] KEEP_ALL  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [KW-1:0] KEEP_LAST = 64'h3FFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [DW-1:0]  data;
    logic           data_valid;
    logic           data_next;
    logic [2:0]     fifo_level;
    logic [31:0]    frame_cnt;
    logic [31:0]    drop_cnt;
    logic [2:0]     sstate;

    logic [DW1-1:0] data1;
    logic           data_valid1;
    logic           data_next1;
    logic [2:0]     fifo_level1;
    logic [31:0]    frame_cnt1;
    logic [31:0]    drop_cnt1;
    logic [2:0]     sstate1;

    axis_frame_packer_if #(.AXIS_DATA_WIDTH(W)) axis0 ();
    axis_frame_packer_if #(.AXIS_DATA_WIDTH(W)) axis1 ();

    axis_frame_packer #(
        .DATA_WIDTH(DW), .AXIS_DATA_WIDTH(W), .SEQ_WIDTH(SW), .DEPTH(DEP)
    ) dut (
        .m_axis_c2h_aclk (clk),
        .rst             (rst),
        .data            (data),
        .data_valid      (data_valid),
        .data_next       (data_next),
        .m_axis_c2h      (axis0),
        .fifo_level      (fifo_level),
        .frame_cnt       (frame_cnt),
        .drop_cnt        (drop_cnt),
        .sstate          (sstate)
    );

    axis_frame_packer #(
        .DATA_WIDTH(DW1), .AXIS_DATA_WIDTH(W), .SEQ_WIDTH(SW), .DEPTH(DEP)
    ) dut1 (
        .m_axis_c2h_aclk (clk),
        .rst             (rst),
        .data            (data1),
        .data_valid      (data_valid1),
        .data_next       (data_next1),
        .m_axis_c2h      (axis1),
        .fifo_level      (fifo_level1),
        .frame_cnt       (frame_cnt1),
        .drop_cnt        (drop_cnt1),
        .sstate          (sstate1)
    );

    // ---------------- beat monitors ----------------
    typedef struct {
        logic [W-1:0]  tdata;
        logic [KW-1:0] tkeep;
        logic          tlast;
        int            cyc;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change 1 ns after the rising edge, so the falling edge sees the
    // values the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst && axis0.tvalid && axis0.tready)
            q0.push_back('{axis0.tdata, axis0.tkeep, axis0.tlast, cyc});
        if (!rst && axis1.tvalid && axis1.tready)
            q1.push_back('{axis1.tdata, axis1.tkeep, axis1.tlast, cyc});
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] seq;
        logic [W-1:0]  beat0;
        logic [W-1:0]  beat1;
    } vec_t;

    vec_t vt [5];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic fail_msg(input string name);
        n_chk++;
        $display("FAIL %s: got nothing within the cycle budget, required an event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push0(input logic [DW-1:0] d);
        int n = 0;
        data = d;
        data_valid = 1'b1;
        while (!data_next && n < 100) begin
            tick();
            n++;
        end
        if (!data_next) fail_msg("push_wait");
        tick();
        data_valid = 1'b0;
    endtask

    task automatic wait_frames0(input logic [31:0] target, input string name);
        int n = 0;
        while (frame_cnt != target && n < 300) begin
            tick();
            n++;
        end
        chk32(name, frame_cnt, target);
    endtask

    task automatic wait_tvalid0(input string name);
        int n = 0;
        while (!axis0.tvalid && n < 50) begin
            tick();
            n++;
        end
        if (!axis0.tvalid) fail_msg(name);
    endtask

    task automatic chk_beat(input string name, input int idx, input logic [W-1:0] exp_d,
                            input logic [KW-1:0] exp_k, input logic exp_l);
        if (idx >= q0.size()) fail_msg(name);
        else begin
            chk({name, "_tdata"}, q0[idx].tdata, exp_d);
            chk32({name, "_tkeep_hi"}, q0[idx].tkeep[63:32], exp_k[63:32]);
            chk32({name, "_tkeep_lo"}, q0[idx].tkeep[31:0], exp_k[31:0]);
            chk32({name, "_tlast"}, 32'(q0[idx].tlast), 32'(exp_l));
        end
    endtask

    logic [7:0]     bv;
    logic [DW-1:0]  d;
    logic [DW1-1:0] d1;
    int             base;

    initial begin
        // Frames: repeating byte with distinct end markers; expected beats
        // follow the {pad, data, seq} LSB-first layout.
        for (int i = 0; i < 5; i++) begin
            bv = 8'hA1 + 8'(i * 17);
            d  = {125{bv}};
            d[999:992] = 8'hC3;
            d[7:0]     = 8'h10 + 8'(i);
            vt[i].data  = d;
            vt[i].seq   = 8'(i);
            vt[i].beat0 = {d[503:0], 8'(i)};
            vt[i].beat1 = {16'h0000, d[999:504]};
        end

        rst = 1'b1;
        data = '0;
        data_valid = 1'b0;
        data1 = '0;
        data_valid1 = 1'b0;
        axis0.tready = 1'b0;
        axis1.tready = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        chk32("rst_tvalid", 32'(axis0.tvalid), 32'd0);
        chk32("rst_tlast", 32'(axis0.tlast), 32'd0);
        chk32("rst_tkeep", axis0.tkeep[31:0], 32'd0);
        chk("rst_tdata", axis0.tdata, '0);
        chk32("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk32("rst_frame_cnt", frame_cnt, 32'd0);
        chk32("rst_drop_cnt", drop_cnt, 32'd0);
        chk32("rst_sstate", 32'(sstate), 32'd1);
        rst = 1'b0;

        // ---- 1: single frame, latency and geometry ----
        axis0.tready = 1'b1;
        base = q0.size();
        data = vt[0].data;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk32("t1_tvalid_t0", 32'(axis0.tvalid), 32'd0);
        tick();
        chk32("t1_tvalid_t1", 32'(axis0.tvalid), 32'd0);
        tick();
        chk32("t1_tvalid_t2", 32'(axis0.tvalid), 32'd1);
        chk32("t1_sstate_send", 32'(sstate), 32'd2);
        wait_frames0(32'd1, "t1_frame_cnt");
        chk32("t1_nbeats", 32'(q0.size() - base), 32'd2);
        chk_beat("t1_b0", base, vt[0].beat0, KEEP_ALL, 1'b0);
        chk_beat("t1_b1", base + 1, vt[0].beat1, KEEP_LAST, 1'b1);
        chk32("t1_tvalid_end", 32'(axis0.tvalid), 32'd0);
        chk32("t1_sstate_idle", 32'(sstate), 32'd1);

        // ---- 2: five frames back-to-back ----
        do_reset();
        base = q0.size();
        for (int i = 0; i < 5; i++) push0(vt[i].data);
        wait_frames0(32'd5, "t2_frame_cnt");
        chk32("t2_nbeats", 32'(q0.size() - base), 32'd10);
        for (int i = 0; i < 5; i++) begin
            if (base + 2 * i < q0.size())
                chk32($sformatf("t2_seq%0d", i), 32'(q0[base + 2 * i].tdata[7:0]), 32'(vt[i].seq));
            else
                fail_msg($sformatf("t2_seq%0d", i));
            chk_beat($sformatf("t2_f%0d_b0", i), base + 2 * i, vt[i].beat0, KEEP_ALL, 1'b0);
            chk_beat($sformatf("t2_f%0d_b1", i), base + 2 * i + 1, vt[i].beat1, KEEP_LAST, 1'b1);
        end
        if (base + 9 < q0.size())
            chk32("t2_no_bubble", 32'(q0[base + 9].cyc - q0[base].cyc), 32'd9);
        else
            fail_msg("t2_no_bubble");

        // ---- 3: stall during beat 1 ----
        do_reset();
        axis0.tready = 1'b0;
        base = q0.size();
        push0(vt[0].data);
        wait_tvalid0("t3_first_valid");
        axis0.tready = 1'b1;
        tick();
        axis0.tready = 1'b0;
        data = vt[1].data;
        data_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("t3_hold_tdata%0d", k), axis0.tdata, vt[0].beat1);
            chk32($sformatf("t3_hold_tkeep%0d", k), axis0.tkeep[63:32], KEEP_LAST[63:32]);
            chk32($sformatf("t3_hold_tlast%0d", k), 32'({axis0.tlast, axis0.tvalid}), 32'd3);
        end
        data_valid = 1'b0;
        chk32("t3_fifo_level", 32'(fifo_level), 32'd4);
`ifdef AXIS_FRAME_DROP_EN
        chk32("t3_drop_cnt", drop_cnt, 32'd16);
`else
        chk32("t3_data_next", 32'(data_next), 32'd0);
        chk32("t3_drop_cnt", drop_cnt, 32'd0);
`endif
        axis0.tready = 1'b1;
        wait_frames0(32'd5, "t3_frame_cnt");
        chk32("t3_nbeats", 32'(q0.size() - base), 32'd10);
        chk32("t3_fifo_empty", 32'(fifo_level), 32'd0);

`ifdef AXIS_FRAME_DROP_EN
        // ---- 4: seven offers into a stalled block ----
        do_reset();
        axis0.tready = 1'b0;
        base = q0.size();
        data_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data = vt[i % 5].data;
            tick();
        end
        data_valid = 1'b0;
        chk32("t4_drop_cnt", drop_cnt, 32'd2);
        axis0.tready = 1'b1;
        wait_frames0(32'd5, "t4_frame_cnt");
        chk32("t4_nbeats", 32'(q0.size() - base), 32'd10);
        for (int i = 0; i < 5; i++) begin
            if (base + 2 * i < q0.size())
                chk32($sformatf("t4_seq%0d", i), 32'(q0[base + 2 * i].tdata[7:0]), 32'(i));
            else
                fail_msg($sformatf("t4_seq%0d", i));
        end
`endif

        // ---- 5: reset mid-packet ----
        do_reset();
        axis0.tready = 1'b1;
        push0(vt[0].data);
        push0(vt[1].data);
        wait_tvalid0("t5_first_valid");
        tick();
        rst = 1'b1;
        tick();
        chk32("t5_tvalid", 32'(axis0.tvalid), 32'd0);
        chk32("t5_fifo_level", 32'(fifo_level), 32'd0);
        chk32("t5_sstate", 32'(sstate), 32'd1);
        rst = 1'b0;
        base = q0.size();
        push0(vt[2].data);
        wait_frames0(32'd1, "t5_frame_cnt");
        if (base < q0.size())
            chk32("t5_seq", 32'(q0[base].tdata[7:0]), 32'd0);
        else
            fail_msg("t5_seq");
        chk_beat("t5_b0", base, {vt[2].data[503:0], 8'h00}, KEEP_ALL, 1'b0);

        // ---- 6: single-beat geometry (DATA_WIDTH=504) ----
        axis1.tready = 1'b1;
        d1 = {63{8'h5B}};
        d1[503:496] = 8'hE7;
        data1 = d1;
        data_valid1 = 1'b1;
        tick();
        data_valid1 = 1'b0;
        for (int n = 0; n < 50 && frame_cnt1 != 32'd1; n++) tick();
        chk32("t6_frame_cnt", frame_cnt1, 32'd1);
        chk32("t6_nbeats", 32'(q1.size()), 32'd1);
        if (q1.size() > 0) begin
            chk("t6_tdata", q1[0].tdata, {d1, 8'h00});
            chk32("t6_tkeep_hi", q1[0].tkeep[63:32], 32'hFFFF_FFFF);
            chk32("t6_tkeep_lo", q1[0].tkeep[31:0], 32'hFFFF_FFFF);
            chk32("t6_tlast", 32'(q1[0].tlast), 32'd1);
        end else begin
            fail_msg("t6_beat");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
